// File: rtl/run_ctrl_sro.sv
// run_ctrl_sro: sequences one program run on the SRO core (go -> start pulse -> halt/watchdog -> done).
// Optional build macro RUN_CTRL_AUTO_ACK_EN: DONE/TOUT self-clear after one cycle and ack_i is unused.
module run_ctrl_sro #(
   parameter int CNT_W     = 32,
   parameter int START_CYC = 2,
   parameter int TIMEOUT   = 1000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go_i,
   input  logic             ack_i,
   input  logic             halt_i,
   output logic             start_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] cycles_o
);
   localparam int ST_W = START_CYC > 1 ? $clog2(START_CYC) : 1;
   typedef enum logic [2:0] {IDLE, START, RUN, DONE, TOUT} state_t;
   state_t           state_q, state_d;
   logic [ST_W-1:0]  st_cnt_q, st_cnt_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d, cycles_q, cycles_d, run_inc;
   logic             ack_w;
`ifdef RUN_CTRL_AUTO_ACK_EN
   logic unused_ack;
   assign unused_ack = ack_i;
   assign ack_w      = 1'b1;
`else
   assign ack_w = ack_i;
`endif
   assign run_inc = run_cnt_q + CNT_W'(1);
   // state and counter registers; async reset drops every output immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         st_cnt_q  <= '0;
         run_cnt_q <= '0;
         cycles_q  <= '0;
      end else begin
         state_q   <= state_d;
         st_cnt_q  <= st_cnt_d;
         run_cnt_q <= run_cnt_d;
         cycles_q  <= cycles_d;
      end
   end
   // next state; halt is only looked at in RUN so a stale halt cannot end the start phase
   always_comb begin
      state_d   = state_q;
      st_cnt_d  = st_cnt_q;
      run_cnt_d = run_cnt_q;
      cycles_d  = cycles_q;
      unique case (state_q)
         IDLE: if (go_i) begin
            state_d  = START;
            st_cnt_d = '0;
            cycles_d = '0;
         end
         START: begin
            st_cnt_d = st_cnt_q + ST_W'(1);
            if (st_cnt_q == ST_W'(START_CYC - 1)) begin
               state_d   = RUN;
               run_cnt_d = '0;
            end
         end
         RUN: begin
            run_cnt_d = run_inc;
            if (halt_i) begin
               state_d  = DONE;
               cycles_d = run_inc;
            end else if (run_inc == CNT_W'(TIMEOUT)) begin
               state_d  = TOUT;
               cycles_d = CNT_W'(TIMEOUT);
            end
         end
         DONE, TOUT: if (ack_w) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // outputs are pure state decodes plus the held cycle count
   always_comb begin
      start_o   = state_q == START;
      busy_o    = state_q == START || state_q == RUN;
      done_o    = state_q == DONE || state_q == TOUT;
      timeout_o = state_q == TOUT;
      cycles_o  = cycles_q;
   end
endmodule

// File: tb/tb_run_ctrl_sro.sv
// tb_run_ctrl_sro: scoreboard bench for run_ctrl_sro with START_CYC=2, TIMEOUT=20.
module tb_run_ctrl_sro;
   localparam int CNT_W     = 32;
   localparam int START_CYC = 2;
   localparam int TIMEOUT   = 20;
   typedef struct {
      logic             tout;
      logic [CNT_W-1:0] cyc;
   } exp_t;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             go_i = 1'b0;
   logic             ack_i = 1'b0;
   logic             halt_i = 1'b0;
   logic             start_o, busy_o, done_o, timeout_o;
   logic [CNT_W-1:0] cycles_o;
   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;

   run_ctrl_sro #(.CNT_W(CNT_W), .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .go_i(go_i), .ack_i(ack_i), .halt_i(halt_i),
      .start_o(start_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
      .cycles_o(cycles_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({start_o, busy_o, done_o, timeout_o} !== 4'b0000 || cycles_o !== '0) begin
         errors++;
         $display("FAIL reset_state: outs=%b cycles=%0d, want 0000 0", {start_o, busy_o, done_o, timeout_o}, cycles_o);
      end
      rst_n = 1'b1;
      step();
      step();
      checks++;
      if ({start_o, busy_o, done_o, timeout_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle: outs=%b, want 0000", {start_o, busy_o, done_o, timeout_o});
      end
   endtask

   task automatic run_prog(input int halt_at, input bit stale, input bit noise, input bit go_held,
                           input bit tout, input int cyc);
      int   n;
      exp_t e;
      e.tout = tout;
      e.cyc  = CNT_W'(cyc);
      sb.push_back(e);
      halt_i = stale;
      go_i   = 1'b1;
      if (!go_held) go_i = 1'b1;
      step();
      go_i = 1'b0;
      checks++;
      if (start_o !== 1'b1 || cycles_o !== '0) begin
         errors++;
         $display("FAIL go_to_start: start=%b cycles=%0d, want 1 0", start_o, cycles_o);
      end
      n = 0;
      while (start_o === 1'b1 && n < 10) begin
         n++;
         step();
      end
      checks++;
      if (n != START_CYC || busy_o !== 1'b1 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL start_len: start cycles=%0d busy=%b done=%b, want %0d 1 0", n, busy_o, done_o, START_CYC);
      end
      n = 1;
      while (busy_o === 1'b1 && n <= TIMEOUT + 5) begin
         halt_i = stale ? (n <= halt_at) : (n == halt_at);
         go_i   = noise && n == 3;
         ack_i  = noise && n == 3;
         step();
         n++;
      end
      halt_i = 1'b0;
      go_i   = 1'b0;
      ack_i  = 1'b0;
      e = sb.pop_front();
      checks++;
      if (done_o !== 1'b1 || timeout_o !== e.tout || cycles_o !== e.cyc || n - 1 != int'(e.cyc)) begin
         errors++;
         $display("FAIL run_result: done=%b timeout=%b cycles=%0d run_len=%0d, want 1 %b %0d %0d",
                  done_o, timeout_o, cycles_o, n - 1, e.tout, e.cyc, e.cyc);
      end
   endtask

   task automatic release_done();
      logic [CNT_W-1:0] keep;
      keep = cycles_o;
`ifdef RUN_CTRL_AUTO_ACK_EN
      step();
      checks++;
      if (done_o !== 1'b0 || timeout_o !== 1'b0 || busy_o !== 1'b0 || cycles_o !== keep) begin
         errors++;
         $display("FAIL auto_ack: done=%b timeout=%b busy=%b cycles=%0d, want 0 0 0 %0d", done_o, timeout_o, busy_o, cycles_o, keep);
      end
`else
      repeat (3) step();
      checks++;
      if (done_o !== 1'b1 || cycles_o !== keep) begin
         errors++;
         $display("FAIL done_hold: done=%b cycles=%0d, want 1 %0d", done_o, cycles_o, keep);
      end
      ack_i = 1'b1;
      step();
      ack_i = 1'b0;
      checks++;
      if (done_o !== 1'b0 || timeout_o !== 1'b0 || busy_o !== 1'b0 || cycles_o !== keep) begin
         errors++;
         $display("FAIL ack_idle: done=%b timeout=%b busy=%b cycles=%0d, want 0 0 0 %0d", done_o, timeout_o, busy_o, cycles_o, keep);
      end
`endif
   endtask

   task automatic test_normal(input int k);
      run_prog(k, 1'b0, 1'b0, 1'b0, 1'b0, k);
      release_done();
   endtask

   task automatic test_stale_halt();
      run_prog(1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      release_done();
   endtask

   task automatic test_timeout();
      run_prog(0, 1'b0, 1'b0, 1'b0, 1'b1, TIMEOUT);
      release_done();
      run_prog(TIMEOUT, 1'b0, 1'b0, 1'b0, 1'b0, TIMEOUT);
      release_done();
   endtask

   task automatic test_ignored();
      run_prog(10, 1'b0, 1'b1, 1'b0, 1'b0, 10);
`ifndef RUN_CTRL_AUTO_ACK_EN
      go_i = 1'b1;
      step();
      go_i = 1'b0;
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || cycles_o !== CNT_W'(10)) begin
         errors++;
         $display("FAIL go_in_done: done=%b busy=%b cycles=%0d, want 1 0 10", done_o, busy_o, cycles_o);
      end
      go_i  = 1'b1;
      ack_i = 1'b1;
      step();
      ack_i = 1'b0;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || cycles_o !== CNT_W'(10)) begin
         errors++;
         $display("FAIL held_go_idle: done=%b busy=%b cycles=%0d, want 0 0 10", done_o, busy_o, cycles_o);
      end
      run_prog(5, 1'b0, 1'b0, 1'b1, 1'b0, 5);
`endif
      release_done();
   endtask

   task automatic test_reset_midrun();
      go_i = 1'b1;
      step();
      go_i = 1'b0;
      repeat (4) step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({start_o, busy_o, done_o, timeout_o} !== 4'b0000 || cycles_o !== '0) begin
         errors++;
         $display("FAIL reset_midrun: outs=%b cycles=%0d, want 0000 0", {start_o, busy_o, done_o, timeout_o}, cycles_o);
      end
      step();
      rst_n = 1'b1;
      step();
      step();
      checks++;
      if ({start_o, busy_o, done_o, timeout_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release_idle: outs=%b, want 0000", {start_o, busy_o, done_o, timeout_o});
      end
   endtask

   initial begin
      test_reset();
      test_normal(10);
      test_stale_halt();
      test_timeout();
      test_ignored();
      test_reset_midrun();
      test_normal(3);
      test_normal(19);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
